// File: rtl/hub75_frame_scanner.sv
// hub75_frame_scanner
//   Reads 24-bit RGB pixels from the read-only port B of a dual-port frame
//   buffer and drives a HUB75 LED panel. The top and bottom halves of the
//   panel are shifted together (1/(ROWS/2) scan). Colour depth comes from
//   binary-coded modulation: plane p is lit for BASE_TICKS<<p cycles.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   enable            run scanning; sampled in IDLE and at the end of a frame
//   mem_addr, mem_re  frame-buffer port B address / read enable
//   mem_dat           port B read data, one cycle after the address
//   r0,g0,b0          top-half serial colour bits
//   r1,g1,b1          bottom-half serial colour bits
//   row_addr          HUB75 row select (A..E)
//   sclk, latch, oe_n panel shift clock, latch strobe, active-low enable
//   frame_done        one-cycle pulse after the last plane of the last row
module hub75_frame_scanner #(
  parameter int COLS       = 64,
  parameter int ROWS       = 36,
  parameter int ADDR_W     = 12,
  parameter int BITS       = 8,
  parameter int BASE_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_re,
  input  logic [23:0]                 mem_dat,
  output logic                        r0,
  output logic                        g0,
  output logic                        b0,
  output logic                        r1,
  output logic                        g1,
  output logic                        b1,
  output logic [$clog2(ROWS/2)-1:0]   row_addr,
  output logic                        sclk,
  output logic                        latch,
  output logic                        oe_n,
  output logic                        frame_done
);

  localparam int HALF = ROWS / 2;
  localparam int RW   = $clog2(HALF);
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TW   = $clog2((BASE_TICKS << (BITS - 1)) + 1);

  if (COLS * ROWS > (1 << ADDR_W)) begin : g_size_check
    $error("hub75_frame_scanner: COLS*ROWS does not fit in ADDR_W address bits");
  end
  if ((ROWS % 2) != 0 || ROWS < 4) begin : g_rows_check
    $error("hub75_frame_scanner: ROWS must be even and at least 4");
  end

  // One-hot encoding so that sclk/latch/oe_n are single flop outputs and
  // therefore glitch-free on their way to the panel.
  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    FETCH_TOP = 7'b0000010,
    FETCH_BOT = 7'b0000100,
    SHIFT_LO  = 7'b0001000,
    SHIFT_HI  = 7'b0010000,
    LATCH     = 7'b0100000,
    DISPLAY   = 7'b1000000
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [PW-1:0]   plane_q;
  logic [TW-1:0]   tick_q;
  logic [RW-1:0]   row_addr_q;
  logic            r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
  logic            frame_done_q;

  logic [ADDR_W-1:0] topAddr, botAddr;
  logic [TW-1:0]     dispLen;
  logic [2:0]        planeIdx;
  logic [7:0]        datR, datG, datB;
  logic              colLast, rowLast, planeLast, dispLast;

  assign topAddr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign botAddr = (ADDR_W'(row_q) + ADDR_W'(HALF)) * ADDR_W'(COLS) + ADDR_W'(col_q);

  assign dispLen   = TW'(BASE_TICKS) << plane_q;
  assign dispLast  = (tick_q == dispLen - TW'(1));
  assign colLast   = (col_q == CW'(COLS - 1));
  assign rowLast   = (row_q == RW'(HALF - 1));
  assign planeLast = (plane_q == PW'(BITS - 1));

  assign planeIdx = 3'(plane_q);
  assign datR     = mem_dat[23:16];
  assign datG     = mem_dat[15:8];
  assign datB     = mem_dat[7:0];

  // The RAM samples the address at the end of the fetch cycle, so the address
  // must be a pure decode of registered state rather than a next-state value.
  always_comb begin
    mem_addr = '0;
    if (state_q[1]) begin
      mem_addr = topAddr;
    end else if (state_q[2]) begin
      mem_addr = botAddr;
    end
  end

  assign mem_re = state_q[1] | state_q[2];
  assign sclk   = state_q[4];
  assign latch  = state_q[5];
  assign oe_n   = ~state_q[6];

  assign r0         = r0_q;
  assign g0         = g0_q;
  assign b0         = b0_q;
  assign r1         = r1_q;
  assign g1         = g1_q;
  assign b1         = b1_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

  // Scan sequencer. Each column costs four cycles: the top pixel arrives in
  // FETCH_BOT, the bottom pixel in SHIFT_LO, and sclk rises in SHIFT_HI.
  // After the last column the row is latched and shown for the BCM weight of
  // the current plane; planes advance first, then rows, then the frame wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      tick_q       <= '0;
      row_addr_q   <= '0;
      r0_q         <= 1'b0;
      g0_q         <= 1'b0;
      b0_q         <= 1'b0;
      r1_q         <= 1'b0;
      g1_q         <= 1'b0;
      b1_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) state_q <= FETCH_TOP;
        end
        FETCH_TOP: begin
          state_q <= FETCH_BOT;
        end
        FETCH_BOT: begin
          r0_q    <= datR[planeIdx];
          g0_q    <= datG[planeIdx];
          b0_q    <= datB[planeIdx];
          state_q <= SHIFT_LO;
        end
        SHIFT_LO: begin
          r1_q    <= datR[planeIdx];
          g1_q    <= datG[planeIdx];
          b1_q    <= datB[planeIdx];
          state_q <= SHIFT_HI;
        end
        SHIFT_HI: begin
          if (colLast) begin
            // Row select is loaded on entry to LATCH so it only ever moves
            // while the panel is blanked.
            col_q      <= '0;
            row_addr_q <= row_q;
            state_q    <= LATCH;
          end else begin
            col_q   <= col_q + CW'(1);
            state_q <= FETCH_TOP;
          end
        end
        LATCH: begin
          tick_q  <= '0;
          state_q <= DISPLAY;
        end
        DISPLAY: begin
          if (dispLast) begin
            tick_q  <= '0;
            state_q <= FETCH_TOP;
            if (planeLast) begin
              plane_q <= '0;
              if (rowLast) begin
                row_q        <= '0;
                frame_done_q <= 1'b1;
                if (!enable) state_q <= IDLE;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              plane_q <= plane_q + PW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_frame_scanner.sv
// Bench for hub75_frame_scanner. A small 4x4, 2-plane instance is checked
// through a scoreboard (expected shifts, latched rows, display lengths and
// frame intervals queued by the stimulus, popped by a monitor). A full-size
// 64x36 instance is checked for address and colour of one chosen pixel.
module tb_hub75_frame_scanner;

  localparam int S_COLS = 4;
  localparam int S_ROWS = 4;
  localparam int S_BITS = 2;
  localparam int S_BASE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        rst, enable;
  logic [3:0]  memAddr;
  logic        memRe;
  logic [23:0] memDat;
  logic        r0, g0, b0, r1, g1, b1;
  logic [0:0]  rowAddr;
  logic        sclk, latch, oeN, frameDone;

  // Full-size instance signals
  logic        bRst, bEnable;
  logic [11:0] bMemAddr;
  logic        bMemRe;
  logic [23:0] bMemDat;
  logic        bR0, bG0, bB0, bR1, bG1, bB1;
  logic [4:0]  bRowAddr;
  logic        bSclk, bLatch, bOeN, bFrameDone;

  logic [23:0] smallRam [16];
  logic [23:0] bigRam [4096];

  int checks = 0;
  int errors = 0;
  bit bigDone = 1'b0;

  int shiftQ[$];
  int latchQ[$];
  int oeQ[$];
  int fdQ[$];

  int oeRun = 0;
  int sclkCount = 0;
  int cyc = 0;
  int lastFd = 0;
  bit haveLast = 1'b0;
  logic [0:0] prevRow = 1'b0;

  hub75_frame_scanner #(
    .COLS(S_COLS), .ROWS(S_ROWS), .ADDR_W(4), .BITS(S_BITS), .BASE_TICKS(S_BASE)
  ) dutSmall (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_addr(memAddr), .mem_re(memRe), .mem_dat(memDat),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .row_addr(rowAddr), .sclk(sclk), .latch(latch), .oe_n(oeN),
    .frame_done(frameDone)
  );

  hub75_frame_scanner #(
    .COLS(64), .ROWS(36), .ADDR_W(12), .BITS(8), .BASE_TICKS(4)
  ) dutBig (
    .clk(clk), .rst(bRst), .enable(bEnable),
    .mem_addr(bMemAddr), .mem_re(bMemRe), .mem_dat(bMemDat),
    .r0(bR0), .g0(bG0), .b0(bB0), .r1(bR1), .g1(bG1), .b1(bB1),
    .row_addr(bRowAddr), .sclk(bSclk), .latch(bLatch), .oe_n(bOeN),
    .frame_done(bFrameDone)
  );

  // Frame buffers with a one-cycle registered read
  always @(posedge clk) if (memRe) memDat <= smallRam[memAddr];
  always @(posedge clk) if (bMemRe) bMemDat <= bigRam[bMemAddr];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue the expected panel activity for one row-plane of the small panel
  task automatic applyStimulus(input int row, input int plane, input bit withOe);
    logic [23:0] top, bot;
    for (int c = 0; c < S_COLS; c++) begin
      top = smallRam[row * S_COLS + c] >> plane;
      bot = smallRam[(row + S_ROWS / 2) * S_COLS + c] >> plane;
      shiftQ.push_back(int'({top[16], top[8], top[0], bot[16], bot[8], bot[0]}));
    end
    latchQ.push_back(row);
    if (withOe) oeQ.push_back(S_BASE << plane);
  endtask

  task automatic pushFrame();
    for (int r = 0; r < S_ROWS / 2; r++)
      for (int p = 0; p < S_BITS; p++)
        applyStimulus(r, p, 1'b1);
  endtask

  task automatic waitFrameDone(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameDone && n < budget);
    if (!frameDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_done wait: got no pulse in %0d cycles, expected one", n);
    end
  endtask

  task automatic checkIdle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput("idle oe_n", int'(oeN), 1);
      checkOutput("idle mem_re", int'(memRe), 0);
      checkOutput("idle sclk", int'(sclk), 0);
      checkOutput("idle latch", int'(latch), 0);
      checkOutput("idle frame_done", int'(frameDone), 0);
    end
  endtask

  task automatic checkQueuesEmpty();
    checkOutput("shift queue drained", shiftQ.size(), 0);
    checkOutput("latch queue drained", latchQ.size(), 0);
    checkOutput("oe queue drained", oeQ.size(), 0);
    checkOutput("frame queue drained", fdQ.size(), 0);
  endtask

  // Monitor: samples just after each rising edge and pops expectations
  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        oeRun = 0;
        sclkCount = 0;
        haveLast = 1'b0;
      end else begin
        if (sclk) begin
          sclkCount++;
          if (shiftQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL shift: got unexpected sclk pulse at cycle %0d, expected none", cyc);
          end else begin
            checkOutput("shift bits", int'({r0, g0, b0, r1, g1, b1}), shiftQ.pop_front());
          end
        end
        if (latch) begin
          checkOutput("latch vs oe_n", int'(oeN), 1);
          checkOutput("sclk pulses per row-plane", sclkCount, S_COLS);
          sclkCount = 0;
          if (latchQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL latch: got unexpected latch at cycle %0d, expected none", cyc);
          end else begin
            checkOutput("latched row_addr", int'(rowAddr), latchQ.pop_front());
          end
        end
        if (!oeN) begin
          oeRun++;
        end else if (oeRun > 0) begin
          if (oeQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL display: got unexpected lit run of %0d, expected none", oeRun);
          end else begin
            checkOutput("oe_n low length", oeRun, oeQ.pop_front());
          end
          oeRun = 0;
        end
        if (frameDone) begin
          if (haveLast) begin
            if (fdQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL frame interval: got unexpected frame_done at cycle %0d, expected none", cyc);
            end else begin
              checkOutput("frame_done interval", cyc - lastFd, fdQ.pop_front());
            end
          end
          lastFd = cyc;
          haveLast = 1'b1;
        end
        if (rowAddr != prevRow) checkOutput("row_addr change while lit", int'(oeN), 1);
      end
      prevRow = rowAddr;
    end
  end

  // Full-size panel: row 1, column 2, plane 0
  initial begin : bigTest
    int n;
    @(negedge bRst);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bMemRe && bMemAddr == 12'd66) && n < 5000);
    checkOutput("big top fetch cycle", n, 3085);
    @(negedge clk);
    checkOutput("big bottom mem_re", int'(bMemRe), 1);
    checkOutput("big bottom addr", int'(bMemAddr), 1218);
    @(negedge clk);
    checkOutput("big top rgb", int'({bR0, bG0, bB0}), 5);
    @(negedge clk);
    checkOutput("big sclk", int'(bSclk), 1);
    checkOutput("big bottom rgb", int'({bR1, bG1, bB1}), 2);
    bigDone = 1'b1;
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    bRst = 1'b1;
    enable = 1'b1;
    bEnable = 1'b1;
    smallRam = '{24'h010203, 24'h020300, 24'h030001, 24'h000102,
                 24'h010101, 24'h020202, 24'h030303, 24'h000000,
                 24'h020100, 24'h010003, 24'h000302, 24'h030201,
                 24'h010302, 24'h020001, 24'h030100, 24'h000203};
    for (int i = 0; i < 4096; i++) bigRam[i] = 24'h000000;
    bigRam[66]   = 24'hFF0001;
    bigRam[1218] = 24'h00FF00;

    // Reset held for three cycles with enable high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mem_re in reset", int'(memRe), 0);
      checkOutput("oe_n in reset", int'(oeN), 1);
    end
    checkOutput("reset mem_addr", int'(memAddr), 0);
    checkOutput("reset rgb", int'({r0, g0, b0, r1, g1, b1}), 0);
    checkOutput("reset row_addr", int'(rowAddr), 0);
    checkOutput("reset sclk", int'(sclk), 0);
    checkOutput("reset latch", int'(latch), 0);
    checkOutput("reset frame_done", int'(frameDone), 0);
    checkOutput("big reset oe_n", int'(bOeN), 1);
    checkOutput("big reset mem_re", int'(bMemRe), 0);

    // Three frames, enable dropped during the third
    fdQ.push_back(80);
    fdQ.push_back(80);
    for (int f = 0; f < 3; f++) pushFrame();
    rst = 1'b0;
    bRst = 1'b0;
    waitFrameDone(300, n);
    checkOutput("first frame latency", n, 81);
    waitFrameDone(300, n);
    checkOutput("second frame length", n, 80);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    waitFrameDone(300, n);
    checkOutput("third frame remainder", n, 70);
    checkIdle(5);
    checkQueuesEmpty();

    // Restart, then reset while row 1 is displayed
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 1, 1'b1);
    applyStimulus(1, 0, 1'b0);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(latch && rowAddr == 1'b1) && n < 300);
    checkOutput("row 1 latch seen", int'(latch && rowAddr == 1'b1), 1);
    @(negedge clk);
    checkOutput("display before reset", int'(oeN), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort oe_n", int'(oeN), 1);
    checkOutput("abort sclk", int'(sclk), 0);
    checkOutput("abort row_addr", int'(rowAddr), 0);
    checkOutput("abort latch", int'(latch), 0);
    checkOutput("abort mem_re", int'(memRe), 0);
    checkOutput("abort shifts consumed", shiftQ.size(), 0);
    checkOutput("abort latches consumed", latchQ.size(), 0);
    pushFrame();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    waitFrameDone(300, n);
    checkOutput("restart frame latency", n + 5, 81);
    checkIdle(3);
    checkQueuesEmpty();

    n = 0;
    while (!bigDone && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!bigDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL big panel: got no pixel fetch in %0d cycles, expected one", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
